// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and the initiator state encoding.
package axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WR_B = 3'd2,
        ST_RD_A = 3'd3,
        ST_RD_R = 3'd4,
        ST_RSP  = 3'd5
    } state_t;

endpackage

// File: rtl/axil_master.sv
// AXI4-Lite initiator: turns single-word commands into AXI4-Lite transactions,
// one outstanding at a time, and returns the slave response on the rsp stream.
module axil_master
    import axil_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    input  logic                  cmd_we,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    state_t                r_state,     w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,      w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata,     w_wdata_nxt;
    logic [STRB_WIDTH-1:0] r_wstrb,     w_wstrb_nxt;
    logic                  r_awvalid,   w_awvalid_nxt;
    logic                  r_wvalid,    w_wvalid_nxt;
    logic                  r_arvalid,   w_arvalid_nxt;
    logic                  r_bready,    w_bready_nxt;
    logic                  r_rready,    w_rready_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]            r_rsp_resp,  w_rsp_resp_nxt;

    // Per-channel completion in WR: a channel is done once its valid is no longer pending.
    logic w_aw_done;
    logic w_w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= AXI_RESP_OKAY;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_arvalid_nxt   = r_arvalid;
        w_bready_nxt    = r_bready;
        w_rready_nxt    = r_rready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;
        w_aw_done       = !r_awvalid || m_axil_awready;
        w_w_done        = !r_wvalid  || m_axil_wready;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_addr_nxt  = cmd_addr;
                    w_wdata_nxt = cmd_wdata;
                    w_wstrb_nxt = cmd_wstrb;
                    if (cmd_we) begin
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_state_nxt   = ST_WR;
                    end else begin
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = ST_RD_A;
                    end
                end
            end
            ST_WR: begin
                if (m_axil_awready) w_awvalid_nxt = 1'b0;
                if (m_axil_wready)  w_wvalid_nxt  = 1'b0;
                if (w_aw_done && w_w_done) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (m_axil_bvalid && r_bready) begin
                    w_rsp_resp_nxt  = m_axil_bresp;
                    w_rsp_rdata_nxt = '0;
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = ST_RSP;
                end
            end
            ST_RD_A: begin
                if (m_axil_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = ST_RD_R;
                end
            end
            ST_RD_R: begin
                if (m_axil_rvalid && r_rready) begin
                    w_rsp_rdata_nxt = m_axil_rdata;
                    w_rsp_resp_nxt  = m_axil_rresp;
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready      = (r_state == ST_IDLE);
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_resp       = r_rsp_resp;
    assign rsp_valid      = r_rsp_valid;
    assign m_axil_awaddr  = r_addr;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = r_awvalid;
    assign m_axil_wdata   = r_wdata;
    assign m_axil_wstrb   = r_wstrb;
    assign m_axil_wvalid  = r_wvalid;
    assign m_axil_bready  = r_bready;
    assign m_axil_araddr  = r_addr;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = r_arvalid;
    assign m_axil_rready  = r_rready;

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: stalling memory-backed slave, protocol monitor and a
// command-level reference memory that predicts every response.
module tb_axil_master;

    localparam int unsigned TMO = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        cmd_we;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axil_master dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .cmd_we(cmd_we), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Slave stall controls and response codes, set by the stimulus process.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;

    logic [31:0] slave_mem [0:63];
    logic        aw_got, w_got, ar_got;
    logic [15:0] aw_q, ar_q;
    logic [31:0] wd_q;
    logic [3:0]  ws_q;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = old;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
        return m;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_q <= '0; ar_q <= '0; wd_q <= '0; ws_q <= '0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
        end else begin
            if (awvalid && awready) begin
                aw_got <= 1'b1; aw_q <= awaddr; awready <= 1'b0; aw_cnt <= 0;
            end else if (awvalid && !aw_got && !awready) begin
                if (aw_cnt >= aw_dly) awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && wready) begin
                w_got <= 1'b1; wd_q <= wdata; ws_q <= wstrb; wready <= 1'b0; w_cnt <= 0;
            end else if (wvalid && !w_got && !wready) begin
                if (w_cnt >= w_dly) wready <= 1'b1; else w_cnt <= w_cnt + 1;
            end
            if (bvalid) begin
                if (bready) begin bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; end
            end else if (aw_got && w_got) begin
                if (b_cnt >= b_dly) begin
                    bvalid <= 1'b1; bresp <= cfg_bresp; b_cnt <= 0;
                    slave_mem[aw_q[7:2]] <= merge(slave_mem[aw_q[7:2]], wd_q, ws_q);
                end else b_cnt <= b_cnt + 1;
            end
            if (arvalid && arready) begin
                ar_got <= 1'b1; ar_q <= araddr; arready <= 1'b0; ar_cnt <= 0;
            end else if (arvalid && !ar_got && !arready) begin
                if (ar_cnt >= ar_dly) arready <= 1'b1; else ar_cnt <= ar_cnt + 1;
            end
            if (rvalid) begin
                if (rready) begin rvalid <= 1'b0; ar_got <= 1'b0; end
            end else if (ar_got) begin
                if (r_cnt >= r_dly) begin
                    rvalid <= 1'b1; rdata <= slave_mem[ar_q[7:2]]; rresp <= cfg_rresp; r_cnt <= 0;
                end else r_cnt <= r_cnt + 1;
            end
        end
    end

    // Handshake counting and valid/payload stability watch.
    int          aw_hs = 0, w_hs = 0, ar_hs = 0, viol = 0;
    logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
    logic [15:0] p_awaddr, p_araddr;
    logic [35:0] p_wpay;

    always @(posedge clk) begin
        if (rst) begin
            p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
        end else begin
            if (p_aw && (!awvalid || awaddr !== p_awaddr)) viol++;
            if (p_w  && (!wvalid  || {wstrb, wdata} !== p_wpay)) viol++;
            if (p_ar && (!arvalid || araddr !== p_araddr)) viol++;
            if ((awvalid && awprot !== 3'b000) || (arvalid && arprot !== 3'b000)) viol++;
            if (awvalid && awready) aw_hs++;
            if (wvalid && wready) w_hs++;
            if (arvalid && arready) ar_hs++;
            p_aw = awvalid && !awready; p_awaddr = awaddr;
            p_w  = wvalid && !wready;   p_wpay = {wstrb, wdata};
            p_ar = arvalid && !arready; p_araddr = araddr;
        end
    end

    // Reference memory at command granularity.
    logic [31:0] ref_mem [int];
    int n_wr = 0, n_rd = 0;

    function automatic logic [31:0] model_read(input logic [15:0] a);
        int k;
        k = int'(a[15:2]);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        ref_mem[int'(a[15:2])] = merge(model_read(a), d, s);
    endtask

    task automatic do_cmd(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int hold, input logic [1:0] xresp,
                          input string tag);
        logic [31:0] exp_d, held_d;
        logic [1:0]  held_r;
        int n, bad;
        exp_d = we ? 32'h0 : model_read(addr);
        @(negedge clk);
        cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < TMO) begin @(negedge clk); n++; end
        chk({tag, "_accept"}, 32'(n < TMO), 32'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < TMO) begin @(negedge clk); n++; end
        chk({tag, "_rsp_seen"}, 32'(rsp_valid), 32'h1);
        if (we) begin model_write(addr, wd, ws); n_wr++; end else n_rd++;
        chk({tag, "_rdata"}, rsp_rdata, exp_d);
        chk({tag, "_resp"}, 32'(rsp_resp), 32'(xresp));
        held_d = rsp_rdata; held_r = rsp_resp; bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== held_d || rsp_resp !== held_r || cmd_ready
                || awvalid || wvalid || arvalid) bad++;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, 32'(bad), 32'h0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 32'({rsp_valid, cmd_ready}), 32'b01);
    endtask

    task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    initial begin
        int hs_aw0, hs_w0;
        logic        we;
        logic [15:0] a;
        logic [1:0]  xr;

        for (int i = 0; i < 64; i++) slave_mem[i] = 32'h0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'h0);
        chk("rst_rsp", 32'({rsp_rdata[15:0], 14'h0, rsp_resp}), 32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rst_addr", 32'(awaddr), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        do_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 2'b00, "t1_wr");
        do_cmd(1'b0, 16'h0010, 32'h0,        4'h0, 0, 2'b00, "t1_rd");
        chk("t1_value", rsp_rdata, 32'hDEADBEEF);

        do_cmd(1'b1, 16'h0020, 32'h11223344, 4'hF, 0, 2'b00, "t2_wr_full");
        do_cmd(1'b1, 16'h0020, 32'hAABBCCDD, 4'h5, 0, 2'b00, "t2_wr_part");
        do_cmd(1'b0, 16'h0020, 32'h0,        4'h0, 0, 2'b00, "t2_rd");
        chk("t2_value", rsp_rdata, 32'h11BB33DD);

        set_dly(3, 0, 1, 0, 0);
        hs_aw0 = aw_hs; hs_w0 = w_hs;
        do_cmd(1'b1, 16'h0030, 32'hCAFEF00D, 4'hF, 0, 2'b00, "t3_w_first");
        chk("t3a_hs", 32'({aw_hs - hs_aw0, w_hs - hs_w0}), 32'({32'd1, 32'd1}));
        set_dly(0, 3, 0, 0, 0);
        hs_aw0 = aw_hs; hs_w0 = w_hs;
        do_cmd(1'b1, 16'h0034, 32'h0BADC0DE, 4'hF, 0, 2'b00, "t3_aw_first");
        chk("t3b_hs", 32'({aw_hs - hs_aw0, w_hs - hs_w0}), 32'({32'd1, 32'd1}));

        set_dly(0, 0, 0, 0, 0);
        cfg_rresp = 2'b10; cfg_bresp = 2'b11;
        do_cmd(1'b0, 16'h0030, 32'h0,        4'h0, 0, 2'b10, "t4_rd_slverr");
        do_cmd(1'b1, 16'h0038, 32'h55AA55AA, 4'hF, 0, 2'b11, "t4_wr_decerr");
        cfg_rresp = 2'b00; cfg_bresp = 2'b00;

        do_cmd(1'b0, 16'h0034, 32'h0,        4'h0, 5, 2'b00, "t5_rd_hold");
        do_cmd(1'b1, 16'h003C, 32'h12345678, 4'hF, 5, 2'b00, "t5_wr_hold");

        // Abort a write stuck in WR; neither channel gets a handshake before reset.
        set_dly(12, 12, 0, 0, 0);
        @(negedge clk);
        cmd_we = 1'b1; cmd_addr = 16'h0010; cmd_wdata = 32'h0; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_in_wr", 32'({awvalid, wvalid}), 32'b11);
        rst = 1'b1;
        #1;
        chk("t6_rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_cmd_ready", 32'(cmd_ready), 32'h1);
        set_dly(0, 0, 0, 0, 0);
        do_cmd(1'b0, 16'h0010, 32'h0, 4'h0, 0, 2'b00, "t6_rd");
        chk("t6_value", rsp_rdata, 32'hDEADBEEF);

        hs_aw0 = aw_hs; hs_w0 = ar_hs;
        n_wr = 0; n_rd = 0;
        for (int i = 0; i < 40; i++) begin
            set_dly(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            we = 1'($urandom_range(0, 1));
            a  = 16'($urandom_range(0, 15) * 4);
            xr = 2'($urandom_range(0, 3));
            if (we) cfg_bresp = xr; else cfg_rresp = xr;
            do_cmd(we, a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), xr, "rnd");
        end
        chk("rnd_aw_count", 32'(aw_hs - hs_aw0), 32'(n_wr));
        chk("rnd_ar_count", 32'(ar_hs - hs_w0), 32'(n_rd));
        chk("aw_w_balance", 32'(aw_hs), 32'(w_hs));
        chk("protocol_viol", 32'(viol), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
